// File: rtl/audio_fifo_pkg.sv
// Shared register map and STATUS bit layout for the audio sample FIFO.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package audio_fifo_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_THRESH = 2'd2;
    localparam logic [1:0] REG_UCOUNT = 2'd3;

    localparam int ST_EMPTY_BIT    = 16;
    localparam int ST_FULL_BIT     = 17;
    localparam int ST_UNDERRUN_BIT = 18;
    localparam int ST_OVERFLOW_BIT = 19;
    localparam int ST_IRQ_EN_BIT   = 24;

    localparam logic [3:0] WSTRB_ALL = 4'hF;
    localparam int         UCOUNT_W  = 16;

    function automatic logic [UCOUNT_W-1:0] sat_inc(input logic [UCOUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; dout always presents the head entry.
// Latency: a push is visible at dout the cycle after it is accepted.
// Backpressure: push into a full FIFO is dropped unless a pop frees the slot that cycle.
module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH_LOG2 = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  empty,
    output logic                  full
);

    localparam int                DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LVL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      r_mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [WIDTH-1:0]      r_rd_dat;
    logic [WIDTH-1:0]      r_byp_dat;
    logic                  r_byp;

    logic                  w_do_push;
    logic                  w_do_pop;
    logic [DEPTH_LOG2-1:0] w_rd_addr;

    assign empty     = (r_level == '0);
    assign full      = (r_level == LVL_FULL);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign w_rd_addr = w_do_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_byp    <= 1'b0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (!w_do_push && w_do_pop) begin
                r_level <= r_level - 1'b1;
            end
            // Registered RAM read cannot see a same-cycle write to the next head slot.
            r_byp <= w_do_push && (r_wr_ptr == w_rd_addr);
        end
    end

    // Synchronous-read storage, no reset, so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
        r_rd_dat  <= r_mem[w_rd_addr];
        r_byp_dat <= din;
    end

    assign dout  = r_byp ? r_byp_dat : r_rd_dat;
    assign level = r_level;

endmodule

// File: rtl/audio_sample_fifo.sv
// Stereo sample FIFO on iomem feeding i2s_tx; AUDIO_FIFO_UNDERRUN_CNT_EN adds the UCOUNT underrun counter.
// Latency: bus ack 1 cycle after request; channel outputs update 3 cycles after an lrclk rising edge.
// Backpressure: none; pushes to a full FIFO are dropped (overflow flag), pops from empty emit 0 (underrun flag).
module audio_sample_fifo
    import audio_fifo_pkg::*;
#(
    parameter int         BITSIZE    = 16,
    parameter int         DEPTH_LOG2 = 6,
    parameter logic [7:0] ADDR_PAGE  = 8'h05
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               iomem_valid,
    output logic               iomem_ready,
    input  logic [3:0]         iomem_wstrb,
    input  logic [31:0]        iomem_addr,
    input  logic [31:0]        iomem_wdata,
    output logic [31:0]        iomem_rdata,
    input  logic               lrclk,
    output logic [BITSIZE-1:0] left_chan,
    output logic [BITSIZE-1:0] right_chan,
    output logic               irq
);

    localparam logic [DEPTH_LOG2:0] THRESH_RST = (DEPTH_LOG2+1)'(1 << (DEPTH_LOG2 - 1));

    logic                  r_ready;
    logic [31:0]           r_rdata;
    logic                  r_lr_s1;
    logic                  r_lr_s2;
    logic                  r_lr_s3;
    logic [BITSIZE-1:0]    r_left;
    logic [BITSIZE-1:0]    r_right;
    logic                  r_irq;
    logic                  r_irq_en;
    logic                  r_underrun;
    logic                  r_overflow;
    logic [DEPTH_LOG2:0]   r_thresh;

    logic                  w_sel;
    logic [1:0]            w_off;
    logic                  w_is_wr;
    logic                  w_full_wr;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_st_wr;
    logic                  w_ovf_set;
    logic                  w_unf_set;
    logic [2*BITSIZE-1:0]  w_din;
    logic [2*BITSIZE-1:0]  w_fifo_dout;
    logic [DEPTH_LOG2:0]   w_level;
    logic                  w_empty;
    logic                  w_full;
    logic [UCOUNT_W-1:0]   w_ucount;
    logic [31:0]           w_rd_val;
    logic                  w_unused;

    assign w_unused = ^{iomem_addr[23:4], iomem_addr[1:0], iomem_wdata};

    // A request is taken only when ready is low, so each access acks exactly once.
    assign w_sel     = iomem_valid && !r_ready && (iomem_addr[31:24] == ADDR_PAGE);
    assign w_off     = iomem_addr[3:2];
    assign w_is_wr   = |iomem_wstrb;
    assign w_full_wr = (iomem_wstrb == WSTRB_ALL);
    assign w_push    = w_sel && w_full_wr && (w_off == REG_DATA);
    assign w_st_wr   = w_sel && (w_off == REG_STATUS);
    assign w_pop     = r_lr_s2 && !r_lr_s3;
    assign w_din     = {iomem_wdata[16 +: BITSIZE], iomem_wdata[0 +: BITSIZE]};
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_unf_set = w_pop && w_empty;

    sync_fifo #(
        .WIDTH      (2 * BITSIZE),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .dout  (w_fifo_dout),
        .level (w_level),
        .empty (w_empty),
        .full  (w_full)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lr_s1 <= 1'b0;
            r_lr_s2 <= 1'b0;
            r_lr_s3 <= 1'b0;
        end else begin
            r_lr_s1 <= lrclk;
            r_lr_s2 <= r_lr_s1;
            r_lr_s3 <= r_lr_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_left  <= '0;
            r_right <= '0;
        end else if (w_pop) begin
            r_left  <= w_empty ? '0 : w_fifo_dout[2*BITSIZE-1:BITSIZE];
            r_right <= w_empty ? '0 : w_fifo_dout[BITSIZE-1:0];
        end
    end

    // Sticky flags: a new event in the same cycle as a clear wins, so it is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
            r_overflow <= 1'b0;
            r_irq_en   <= 1'b0;
            r_thresh   <= THRESH_RST;
        end else begin
            r_underrun <= w_unf_set ||
                          (r_underrun && !(w_st_wr && iomem_wstrb[2] && iomem_wdata[ST_UNDERRUN_BIT]));
            r_overflow <= w_ovf_set ||
                          (r_overflow && !(w_st_wr && iomem_wstrb[2] && iomem_wdata[ST_OVERFLOW_BIT]));
            if (w_st_wr && iomem_wstrb[3]) begin
                r_irq_en <= iomem_wdata[ST_IRQ_EN_BIT];
            end
            if (w_sel && w_is_wr && (w_off == REG_THRESH)) begin
                r_thresh <= iomem_wdata[DEPTH_LOG2:0];
            end
        end
    end

`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    logic [UCOUNT_W-1:0] r_ucount;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ucount <= '0;
        end else if (w_sel && w_full_wr && (w_off == REG_UCOUNT)) begin
            r_ucount <= '0;
        end else if (w_unf_set) begin
            r_ucount <= sat_inc(r_ucount);
        end
    end

    assign w_ucount = r_ucount;
`else
    assign w_ucount = '0;
`endif

    always_comb begin
        w_rd_val = '0;
        if (!w_is_wr) begin
            case (w_off)
                REG_STATUS: begin
                    w_rd_val[DEPTH_LOG2:0]   = w_level;
                    w_rd_val[ST_EMPTY_BIT]    = w_empty;
                    w_rd_val[ST_FULL_BIT]     = w_full;
                    w_rd_val[ST_UNDERRUN_BIT] = r_underrun;
                    w_rd_val[ST_OVERFLOW_BIT] = r_overflow;
                    w_rd_val[ST_IRQ_EN_BIT]   = r_irq_en;
                end
                REG_THRESH: w_rd_val[DEPTH_LOG2:0] = r_thresh;
                REG_UCOUNT: w_rd_val[UCOUNT_W-1:0] = w_ucount;
                default:    w_rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_sel;
            r_rdata <= w_sel ? w_rd_val : '0;
            r_irq   <= r_irq_en && (w_level <= r_thresh);
        end
    end

    assign iomem_ready = r_ready;
    assign iomem_rdata = r_rdata;
    assign left_chan   = r_left;
    assign right_chan  = r_right;
    assign irq         = r_irq;

endmodule

// File: tb/tb_audio_sample_fifo.sv
// Scoreboard bench for audio_sample_fifo: stimulus queues expectations, monitors compare on ack / scheduled cycles.
module tb_audio_sample_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        lrclk;
    logic [15:0] left_chan;
    logic [15:0] right_chan;
    logic        irq;

    always #5 clk = ~clk;

    audio_sample_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .lrclk       (lrclk),
        .left_chan   (left_chan),
        .right_chan  (right_chan),
        .irq         (irq)
    );

    localparam logic [31:0] A_DATA   = 32'h0500_0000;
    localparam logic [31:0] A_STATUS = 32'h0500_0004;
    localparam logic [31:0] A_THRESH = 32'h0500_0008;
    localparam logic [31:0] A_UCOUNT = 32'h0500_000C;
`ifdef AUDIO_FIFO_UNDERRUN_CNT_EN
    localparam logic [31:0] EXP_UCNT = 32'd1;
`else
    localparam logic [31:0] EXP_UCNT = 32'd0;
`endif

    localparam int S_IRQ = 0, S_LEFT = 1, S_RIGHT = 2, S_READY = 3;

    typedef struct { logic chk; logic [31:0] exp; string name; } bexp_t;
    typedef struct { int cyc; int sel; logic [31:0] exp; string name; } tchk_t;

    bexp_t bq[$];
    tchk_t tq[$];
    int    cyc    = 0;
    int    checks = 0;
    int    errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus monitor: every ack consumes one queued expectation.
    always @(negedge clk) begin : mon_bus
        bexp_t e;
        if (iomem_ready === 1'b1) begin
            if (bq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: iomem_ready=%0b with no request outstanding", iomem_ready);
            end else begin
                e = bq.pop_front();
                if (e.chk) chk(e.name, iomem_rdata, e.exp);
            end
        end
    end

    // Timed monitor: compares channel/irq/ready outputs on the cycle they were scheduled for.
    always @(negedge clk) begin : mon_timed
        tchk_t       t;
        logic [31:0] act;
        for (int i = tq.size() - 1; i >= 0; i--) begin
            if (tq[i].cyc <= cyc) begin
                t = tq[i];
                case (t.sel)
                    S_IRQ:   act = {31'd0, irq};
                    S_LEFT:  act = {16'd0, left_chan};
                    S_RIGHT: act = {16'd0, right_chan};
                    default: act = {31'd0, iomem_ready};
                endcase
                chk(t.name, act, t.exp);
                tq.delete(i);
            end
        end
    end

    task automatic add_t(input int c, input int sel, input logic [31:0] e, input string name);
        tchk_t t;
        t.cyc = c; t.sel = sel; t.exp = e; t.name = name;
        tq.push_back(t);
    endtask

    task automatic bus(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                       input logic chk_en, input logic [31:0] exp, input string name);
        bexp_t e;
        logic  got;
        e.chk = chk_en; e.exp = exp; e.name = name;
        bq.push_back(e);
        iomem_valid = 1'b1;
        iomem_addr  = addr;
        iomem_wstrb = strb;
        iomem_wdata = wd;
        got = 1'b0;
        for (int n = 0; n < 8 && !got; n++) begin
            @(posedge clk);
            #1;
            if (iomem_ready === 1'b1) got = 1'b1;
        end
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_ack_timeout: no iomem_ready within 8 cycles", name);
            void'(bq.pop_back());
        end
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        bus(addr, 4'h0, 32'h0, 1'b1, exp, name);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd);
        bus(addr, strb, wd, 1'b0, 32'h0, "wr");
    endtask

    task automatic pop(input logic [15:0] l, input logic [15:0] r, input string name);
        add_t(cyc + 3, S_LEFT,  {16'd0, l}, {name, "_left"});
        add_t(cyc + 3, S_RIGHT, {16'd0, r}, {name, "_right"});
        lrclk = 1'b1;
        repeat (4) @(posedge clk);
        #1 lrclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pair(input logic [15:0] lb, input logic [15:0] rb, input int i);
        return {lb + 16'(i), rb + 16'(i)};
    endfunction

    initial begin : stim
        logic [31:0] p;
        reset = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        iomem_addr = 32'h0; iomem_wdata = 32'h0; lrclk = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        add_t(cyc, S_IRQ, 0, "rst_irq");
        add_t(cyc, S_LEFT, 0, "rst_left");
        add_t(cyc, S_RIGHT, 0, "rst_right");
        add_t(cyc, S_READY, 0, "rst_ready");
        rd(A_STATUS, 32'h0001_0000, "rst_status");
        rd(A_THRESH, 32'd32, "rst_thresh");
        rd(A_UCOUNT, 32'd0, "rst_ucount");
        rd(A_DATA, 32'd0, "data_read_zero");

        wr(A_DATA, 4'hF, 32'h1234_5678);
        add_t(cyc + 2, S_LEFT, 0, "pop1_left_early");
        pop(16'h1234, 16'h5678, "pop1");
        rd(A_STATUS, 32'h0001_0000, "pop1_status");

        for (int i = 0; i < 65; i++) wr(A_DATA, 4'hF, pair(16'h1000, 16'h2000, i));
        rd(A_STATUS, 32'h000A_0040, "ovf_status");
        wr(A_STATUS, 4'hF, 32'h0008_0000);
        rd(A_STATUS, 32'h0002_0040, "ovf_clear");

        add_t(cyc + 3, S_LEFT, 32'h1000, "pp_left");
        add_t(cyc + 3, S_RIGHT, 32'h2000, "pp_right");
        lrclk = 1'b1;
        repeat (2) @(posedge clk);
        #1 wr(A_DATA, 4'hF, 32'hAAAA_5555);
        repeat (3) @(posedge clk);
        #1 lrclk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rd(A_STATUS, 32'h0002_0040, "pp_status");
        wr(A_DATA, 4'h3, 32'hDEAD_BEEF);
        rd(A_STATUS, 32'h0002_0040, "partial_status");

        for (int i = 1; i < 64; i++) begin
            p = pair(16'h1000, 16'h2000, i);
            pop(p[31:16], p[15:0], "drain");
        end
        pop(16'hAAAA, 16'h5555, "drain_last");

        pop(16'h0000, 16'h0000, "underrun");
        rd(A_STATUS, 32'h0005_0000, "underrun_status");
        rd(A_UCOUNT, EXP_UCNT, "ucount");
        wr(A_UCOUNT, 4'hF, 32'hFFFF_FFFF);
        rd(A_UCOUNT, 32'd0, "ucount_clear");
        wr(A_STATUS, 4'hF, 32'h0004_0000);
        rd(A_STATUS, 32'h0001_0000, "underrun_clear");

        wr(A_THRESH, 4'hF, 32'd4);
        wr(A_STATUS, 4'hF, 32'h0100_0000);
        rd(A_THRESH, 32'd4, "thresh_rw");
        for (int i = 0; i < 6; i++) wr(A_DATA, 4'hF, pair(16'h0100, 16'h0200, i));
        add_t(cyc, S_IRQ, 0, "irq_above");
        rd(A_STATUS, 32'h0100_0006, "irq_status");
        add_t(cyc + 4, S_IRQ, 0, "irq_pop1");
        pop(16'h0100, 16'h0200, "irq_pop1");
        add_t(cyc + 3, S_IRQ, 0, "irq_pop2_pre");
        add_t(cyc + 4, S_IRQ, 1, "irq_pop2_post");
        pop(16'h0101, 16'h0201, "irq_pop2");

        for (int j = 1; j <= 4; j++) add_t(cyc + j, S_READY, 0, "page_noack");
        iomem_addr = 32'h0600_0000; iomem_wstrb = 4'hF; iomem_wdata = 32'h1111_2222;
        iomem_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 iomem_valid = 1'b0; iomem_wstrb = 4'h0;
        rd(A_STATUS, 32'h0100_0004, "page_status");
        add_t(cyc, S_IRQ, 1, "irq_level");

        add_t(cyc + 1, S_READY, 0, "rst_mid_noack");
        add_t(cyc + 1, S_IRQ, 0, "rst_mid_irq");
        add_t(cyc + 1, S_LEFT, 0, "rst_mid_left");
        iomem_addr = A_STATUS; iomem_wstrb = 4'h0; iomem_valid = 1'b1; reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0; iomem_valid = 1'b0;
        rd(A_STATUS, 32'h0001_0000, "rst_mid_status");
        rd(A_THRESH, 32'd32, "rst_mid_thresh");

        repeat (5) @(posedge clk);
        #1;
        if (bq.size() != 0 || tq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d bus and %0d timed expectations never observed", bq.size(), tq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

endmodule

// File: doc/audio_sample_fifo.md
# audio_sample_fifo

Memory-mapped stereo sample buffer between the PicoRV32 iomem bus and the I2S transmitter. Firmware pushes packed left/right sample words over iomem. The block pops one stereo pair on every rising edge of the codec DAC LR clock and presents it to `i2s_tx`. A level-based interrupt tells firmware to refill. It replaces the fixed sine source as the DAC sample provider.

## Interface
- `BITSIZE`, default 16: sample width, 1..16.
- `DEPTH_LOG2`, default 6: FIFO depth = 2^DEPTH_LOG2 stereo pairs.
- `ADDR_PAGE`, default 8'h05: block selected when `iomem_addr[31:24] == ADDR_PAGE`.
- `clk` in 1: system clock, 12 MHz. Single clock.
- `reset` in 1: synchronous, active-high.
- `iomem_valid` in 1: bus request.
- `iomem_ready` out 1: one-cycle acknowledge.
- `iomem_wstrb` in 4: byte write strobes; 0 = read.
- `iomem_addr` in 32: byte address.
- `iomem_wdata` in 32: write data.
- `iomem_rdata` out 32: read data, valid while `iomem_ready` is high.
- `lrclk` in 1: DACLRC from codec, asynchronous.
- `left_chan` out BITSIZE: current left sample to `i2s_tx`.
- `right_chan` out BITSIZE: current right sample to `i2s_tx`.
- `irq` out 1: refill request, level-sensitive, connects to `irq_4`.

## Operation
Register map (word offset = `iomem_addr[3:2]`):
- **0 DATA, W**: push. Left = `wdata[16+BITSIZE-1:16]`, right = `wdata[BITSIZE-1:0]`.
  - Push only when `wstrb == 4'hF`; partial writes are acked and ignored.
  - Reads return 0.
- **1 STATUS**
  - Read: `[DEPTH_LOG2:0]` level, `[16]` empty, `[17]` full, `[18]` underrun sticky, `[19]` overflow sticky, `[24]` irq_en.
  - Write with `wstrb[2]`: 1 to bits 18/19 clears that sticky flag.
  - Write with `wstrb[3]`: loads irq_en from bit 24.
- **2 THRESH, R/W**: low-water mark, `[DEPTH_LOG2:0]`. Reset value is 2^(DEPTH_LOG2-1).
- **3 UCOUNT, R**: underrun counter; see Configuration.

Behaviour:
- **Push when full**: data dropped, overflow flag set, level unchanged.
- **Pop**: on a synchronized `lrclk` rising edge.
  - Not empty: head pair loads into `left_chan`/`right_chan`, level decrements.
  - Empty: outputs load 0, underrun flag set.
- **Push and pop in the same cycle**: both happen and the level is unchanged. When full, the push succeeds because the pop frees the slot that cycle. When empty, the pop sees empty and outputs 0; the pushed word stays in the FIFO.
- **irq**: `irq_en && level <= THRESH`, registered.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Level is DEPTH_LOG2+1 bits, range 0..2^DEPTH_LOG2.
- Accesses outside `ADDR_PAGE`: no `iomem_ready`, no side effects.

## Timing
- **Reset values**: `iomem_ready`=0, `iomem_rdata`=0, `left_chan`=0, `right_chan`=0, `irq`=0. FIFO is empty, sticky flags are 0, irq_en=0, UCOUNT=0.
- **Bus**: `iomem_ready` rises the cycle after `iomem_valid` and stays high for exactly 1 cycle. The next cycle is blocked by `!iomem_ready`. Write side effects become visible on the ready cycle.
- **lrclk**: 2-flop synchronizer, then an edge-detect flop. Outputs update 3 `clk` cycles after the `lrclk` edge, worst case +1 cycle of sampling jitter. At 48 kHz / 12 MHz there are about 250 cycles per frame, so at most one pop per frame.
- **STATUS read**: reflects the state before that cycle's push or pop.
- **irq latency**: 1 cycle after the level crosses THRESH.
- **Reset mid-transfer**: discards FIFO contents. A pending bus request is not acked in the reset cycle.

## Configuration
- `AUDIO_FIFO_UNDERRUN_CNT_EN` defined:
  - 16-bit saturating counter at offset 3, incremented on each empty pop.
  - Cleared by any full-word write to offset 3.
- Undefined: offset 3 reads 0, writes are ignored, and no counter logic is synthesized.

## Structure
- **Shared package `audio_fifo_pkg`**: register offsets (`REG_DATA`=0, `REG_STATUS`=1, `REG_THRESH`=2, `REG_UCOUNT`=3) and STATUS bit positions.
- **Sub-module `sync_fifo`**:
  - Width 2*BITSIZE, DEPTH_LOG2.
  - Ports: push, pop, din, dout, level, empty, full.
  - Simultaneous push/pop legal; memory inferable as iCE40 EBR.
- **Top level**: bus decode, lrclk synchronizer, output registers, flags, irq.

## Test plan
- **Reset and readback**: after reset, read STATUS -> 0x00010000; read THRESH -> 32; `irq`=0.
- **Single pop**: write DATA 0x12345678, then toggle `lrclk` -> 3 cycles later `left_chan`=0x1234, `right_chan`=0x5678; STATUS level 0, empty=1.
- **Overflow**: 65 writes with DEPTH_LOG2=6 -> level 64, full=1, overflow=1; write 0x00080000 to STATUS -> overflow=0.
- **Underrun**: pop with an empty FIFO -> outputs 0, underrun=1; with the macro defined UCOUNT=1, without it UCOUNT reads 0.
- **irq**: THRESH=4, irq_en=1, push 6 -> `irq`=0. After 2 pops, `irq`=1 one cycle after the second pop.
- **Simultaneous push/pop**: push and pop in the same cycle at full -> level stays 64, no overflow flag. Partial write with `wstrb`=4'h3 to DATA -> acked, level unchanged.
